reg_file: RTL and testbench



---
 rtl/reg_file_pkg.sv | 12 +
 rtl/reg_file_if.sv | 29 ++
 rtl/reg_file_read_port.sv | 45 ++++
 rtl/reg_file.sv | 80 ++++++++
 tb/tb_reg_file.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants for the register file and ID's register-address generator.
package reg_file_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int REG_NUM_DEF    = 32;

    // Architectural register numbers that the decode stage also depends on
    localparam logic [ADDR_WIDTH_DEF-1:0] ZERO_REG = 5'd0;
    localparam logic [ADDR_WIDTH_DEF-1:0] RA_REG   = 5'd31;

endpackage

// File: rtl/reg_file_if.sv
// Read/write/debug bus of the register file; master is the pipeline, slave is the file.
interface reg_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  read_en_1;
    logic [ADDR_WIDTH-1:0] read_addr_1;
    logic [DATA_WIDTH-1:0] read_data_1;
    logic                  read_en_2;
    logic [ADDR_WIDTH-1:0] read_addr_2;
    logic [DATA_WIDTH-1:0] read_data_2;
    logic                  write_en;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic [ADDR_WIDTH-1:0] debug_addr;
    logic [DATA_WIDTH-1:0] debug_data;

    modport master (
        output read_en_1, read_addr_1, read_en_2, read_addr_2,
               write_en, write_addr, write_data, debug_addr,
        input  read_data_1, read_data_2, debug_data
    );

    modport slave (
        input  read_en_1, read_addr_1, read_en_2, read_addr_2,
               write_en, write_addr, write_data, debug_addr,
        output read_data_1, read_data_2, debug_data
    );
endinterface

// File: rtl/reg_file_read_port.sv
// One read port: enable / $zero / write-through bypass / storage priority mux.
// Bypass only exists when REG_FILE_BYPASS_EN is defined.
module reg_read_port
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  rst_i,
    input  logic                  read_en_i,
    input  logic [ADDR_WIDTH-1:0] read_addr_i,
    input  logic [DATA_WIDTH-1:0] store_word_i,
    input  logic                  write_en_i,
    input  logic [ADDR_WIDTH-1:0] write_addr_i,
    input  logic [DATA_WIDTH-1:0] write_data_i,
    output logic [DATA_WIDTH-1:0] read_data_o
);

    logic bypass_hit;

`ifdef REG_FILE_BYPASS_EN
    // A write that reset is about to drop must not be forwarded either
    assign bypass_hit = rst_i && write_en_i &&
                        (write_addr_i != ADDR_WIDTH'(ZERO_REG)) &&
                        (write_addr_i == read_addr_i);
`else
    logic unused_bypass;
    assign bypass_hit    = 1'b0;
    assign unused_bypass = ^{rst_i, write_en_i, write_addr_i, write_data_i};
`endif

    always_comb begin
        read_data_o = '0;
        if (!read_en_i) begin
            read_data_o = '0;
        end else if (read_addr_i == ADDR_WIDTH'(ZERO_REG)) begin
            read_data_o = '0;
        end else if (bypass_hit) begin
            read_data_o = write_data_i;
        end else begin
            read_data_o = store_word_i;
        end
    end

endmodule

// File: rtl/reg_file.sv
// 32x32 MIPS general-purpose register file: two combinational read ports, one write port,
// $zero hardwired, debug peek. Optional write-through bypass under REG_FILE_BYPASS_EN.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int REG_NUM    = REG_NUM_DEF
) (
    input  logic       clk,
    input  logic       rst,
    reg_file_if.slave  bus
);

    // Entry 0 has no storage; every lookup of address 0 yields zero instead
    logic [DATA_WIDTH-1:0] regs_q [1:REG_NUM-1];
    logic [DATA_WIDTH-1:0] regs_d [1:REG_NUM-1];

    logic [DATA_WIDTH-1:0] store_word_1;
    logic [DATA_WIDTH-1:0] store_word_2;

    always_comb begin
        regs_d = regs_q;
        if (!rst) begin
            for (int i = 1; i < REG_NUM; i++) begin
                regs_d[i] = '0;
            end
        end else if (bus.write_en && (bus.write_addr != ADDR_WIDTH'(ZERO_REG))) begin
            regs_d[bus.write_addr] = bus.write_data;
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    always_comb begin
        store_word_1   = '0;
        store_word_2   = '0;
        bus.debug_data = '0;
        if (bus.read_addr_1 != ADDR_WIDTH'(ZERO_REG)) begin
            store_word_1 = regs_q[bus.read_addr_1];
        end
        if (bus.read_addr_2 != ADDR_WIDTH'(ZERO_REG)) begin
            store_word_2 = regs_q[bus.read_addr_2];
        end
        if (bus.debug_addr != ADDR_WIDTH'(ZERO_REG)) begin
            bus.debug_data = regs_q[bus.debug_addr];
        end
    end

    reg_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_read_port_1 (
        .rst_i        (rst),
        .read_en_i    (bus.read_en_1),
        .read_addr_i  (bus.read_addr_1),
        .store_word_i (store_word_1),
        .write_en_i   (bus.write_en),
        .write_addr_i (bus.write_addr),
        .write_data_i (bus.write_data),
        .read_data_o  (bus.read_data_1)
    );

    reg_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_read_port_2 (
        .rst_i        (rst),
        .read_en_i    (bus.read_en_2),
        .read_addr_i  (bus.read_addr_2),
        .store_word_i (store_word_2),
        .write_en_i   (bus.write_en),
        .write_addr_i (bus.write_addr),
        .write_data_i (bus.write_data),
        .read_data_o  (bus.read_data_2)
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed and randomized bench for reg_file; expectations follow REG_FILE_BYPASS_EN.
module tb_reg_file;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [31:0] model [32];

    reg_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .REG_NUM(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.read_en_1   = 1'b0;
        bus.read_addr_1 = '0;
        bus.read_en_2   = 1'b0;
        bus.read_addr_2 = '0;
        bus.write_en    = 1'b0;
        bus.write_addr  = '0;
        bus.write_data  = '0;
        bus.debug_addr  = '0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.write_en   = 1'b1;
        bus.write_addr = a;
        bus.write_data = d;
        step();
        bus.write_en   = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
        bus.read_en_1   = 1'b1;
        bus.read_addr_1 = a1;
        bus.read_en_2   = 1'b1;
        bus.read_addr_2 = a2;
        bus.debug_addr  = ad;
        #1;
    endtask

    function automatic logic [31:0] exp_port(input logic en, input logic [4:0] a);
        if (!en || a == 5'd0) return 32'h0;
        if (BYPASS && rst && bus.write_en && bus.write_addr != 5'd0 && bus.write_addr == a)
            return bus.write_data;
        return model[a];
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        idle();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;

        // Reset state
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(31 - i), 5'(i));
            check($sformatf("rst_p1_r%0d", i), bus.read_data_1, 32'h0);
            check($sformatf("rst_dbg_r%0d", i), bus.debug_data, 32'h0);
        end
        idle();

        // Preload then reset clears everything
        for (int i = 1; i < 32; i++) wr(5'(i), 32'hA5A5_0000 | i);
        rd(5'd3, 5'd31, 5'd17);
        check("pre_p1_r3", bus.read_data_1, 32'hA5A5_0003);
        check("pre_p2_r31", bus.read_data_2, 32'hA5A5_001F);
        check("pre_dbg_r17", bus.debug_data, 32'hA5A5_0011);
        rst = 1'b0;
        #1;
        check("inrst_p1_old", bus.read_data_1, 32'hA5A5_0003);
        step();
        rst = 1'b1;
        for (int i = 1; i < 32; i++) begin
            rd(5'(i), 5'(i), 5'(i));
            check($sformatf("clr_p1_r%0d", i), bus.read_data_1, 32'h0);
            check($sformatf("clr_p2_r%0d", i), bus.read_data_2, 32'h0);
            check($sformatf("clr_dbg_r%0d", i), bus.debug_data, 32'h0);
        end
        idle();

        // Basic write/read, disabled port returns zero
        wr(5'd8, 32'hDEAD_BEEF);
        rd(5'd8, 5'd8, 5'd8);
        bus.read_en_2 = 1'b0;
        #1;
        check("wr_p1_r8", bus.read_data_1, 32'hDEAD_BEEF);
        check("wr_p2_dis", bus.read_data_2, 32'h0);
        check("wr_dbg_r8", bus.debug_data, 32'hDEAD_BEEF);
        idle();

        // $zero discards writes
        bus.write_en   = 1'b1;
        bus.write_addr = 5'd0;
        bus.write_data = 32'h1234_5678;
        rd(5'd0, 5'd0, 5'd0);
        check("z_same_p1", bus.read_data_1, 32'h0);
        check("z_same_p2", bus.read_data_2, 32'h0);
        check("z_same_dbg", bus.debug_data, 32'h0);
        step();
        bus.write_en = 1'b0;
        #1;
        check("z_next_p1", bus.read_data_1, 32'h0);
        check("z_next_p2", bus.read_data_2, 32'h0);
        check("z_next_dbg", bus.debug_data, 32'h0);
        idle();

        // Same-cycle collision on r5
        wr(5'd5, 32'h1111_1111);
        bus.write_en   = 1'b1;
        bus.write_addr = 5'd5;
        bus.write_data = 32'h2222_2222;
        rd(5'd5, 5'd5, 5'd5);
        check("col_p1", bus.read_data_1, BYPASS ? 32'h2222_2222 : 32'h1111_1111);
        check("col_p2", bus.read_data_2, BYPASS ? 32'h2222_2222 : 32'h1111_1111);
        check("col_dbg", bus.debug_data, 32'h1111_1111);
        step();
        bus.write_en = 1'b0;
        #1;
        check("col_next_p1", bus.read_data_1, 32'h2222_2222);
        check("col_next_p2", bus.read_data_2, 32'h2222_2222);
        idle();

        // Reset drops a concurrent write and suppresses bypass
        wr(5'd9, 32'h0000_0009);
        rst            = 1'b0;
        bus.write_en   = 1'b1;
        bus.write_addr = 5'd9;
        bus.write_data = 32'hFFFF_FFFF;
        rd(5'd9, 5'd9, 5'd9);
        check("rstwr_p1_nobyp", bus.read_data_1, 32'h0000_0009);
        check("rstwr_p2_nobyp", bus.read_data_2, 32'h0000_0009);
        step();
        rst          = 1'b1;
        bus.write_en = 1'b0;
        #1;
        check("rstwr_p1_after", bus.read_data_1, 32'h0);
        check("rstwr_dbg_after", bus.debug_data, 32'h0);
        idle();

        // Random sweep against a reference array (storage currently all zero)
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        for (int n = 0; n < 10000; n++) begin
            rst             = ($urandom_range(0, 199) != 0);
            bus.read_en_1   = 1'($urandom_range(0, 3) != 0);
            bus.read_addr_1 = 5'($urandom_range(0, 31));
            bus.read_en_2   = 1'($urandom_range(0, 3) != 0);
            bus.read_addr_2 = ($urandom_range(0, 3) == 0) ? bus.read_addr_1 : 5'($urandom_range(0, 31));
            bus.write_en    = 1'($urandom_range(0, 1));
            bus.write_addr  = ($urandom_range(0, 3) == 0) ? bus.read_addr_1 : 5'($urandom_range(0, 31));
            bus.write_data  = $urandom;
            bus.debug_addr  = 5'($urandom_range(0, 31));
            #1;
            check("rnd_p1", bus.read_data_1, exp_port(bus.read_en_1, bus.read_addr_1));
            check("rnd_p2", bus.read_data_2, exp_port(bus.read_en_2, bus.read_addr_2));
            check("rnd_dbg", bus.debug_data, model[bus.debug_addr]);
            @(posedge clk);
            if (!rst) begin
                for (int i = 1; i < 32; i++) model[i] = 32'h0;
            end else if (bus.write_en && bus.write_addr != 5'd0) begin
                model[bus.write_addr] = bus.write_data;
            end
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
